// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle DIV/DIVU/REM/REMU unit for the RISC-V M extension.
// Restoring division, one quotient bit per cycle. Divide-by-zero and signed
// overflow bypass the iteration and return the architecturally defined results.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      fn3,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST    = CW'(XLEN-1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    SPECIAL = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_q,  state_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [XLEN:0]   rem_q,    rem_d;
  logic [XLEN-1:0] quo_q,    quo_d;     // dividend magnitude shifting into quotient
  logic [XLEN-1:0] dvsr_q,   dvsr_d;    // divisor magnitude
  logic [1:0]      op_q,     op_d;      // fn3[1:0]: [1]=remainder, [0]=unsigned
  logic            neg1_q,   neg1_d;    // dividend negative (signed ops only)
  logic            neg2_q,   neg2_d;    // divisor negative (signed ops only)
  logic            divz_q,   divz_d;    // special path: divide by zero vs overflow
  logic [XLEN-1:0] result_q, result_d;

  // Request decode in IDLE: operand signs, magnitudes and special-case detection
  logic            req_signed;
  logic            req_neg1, req_neg2;
  logic [XLEN-1:0] req_mag1, req_mag2;
  logic            req_divz, req_ovf;

  always_comb begin
    req_signed = ~fn3[0];
    req_neg1   = req_signed & rs1_data[XLEN-1];
    req_neg2   = req_signed & rs2_data[XLEN-1];
    req_mag1   = req_neg1 ? (~rs1_data + ONE) : rs1_data;
    req_mag2   = req_neg2 ? (~rs2_data + ONE) : rs2_data;
    req_divz   = (rs2_data == '0);
    req_ovf    = req_signed & (rs1_data == INT_MIN) & (rs2_data == '1);
  end

  // One restoring-division step plus the sign fix applied to its outcome
  logic [XLEN:0]   rem_sh, diff, rem_nx;
  logic [XLEN-1:0] quo_nx, q_fix, r_fix;

  always_comb begin
    rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvsr_q};
    rem_nx = diff[XLEN] ? rem_sh : diff;
    quo_nx = {quo_q[XLEN-2:0], ~diff[XLEN]};
    q_fix  = (~op_q[0] & (neg1_q ^ neg2_q)) ? (~quo_nx + ONE) : quo_nx;
    r_fix  = (~op_q[0] & neg1_q) ? (~rem_nx[XLEN-1:0] + ONE) : rem_nx[XLEN-1:0];
  end

  // Next-state and datapath update; flush overrides every transition
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    op_d     = op_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    divz_d   = divz_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (start && fn3[2]) begin
          op_d    = fn3[1:0];
          neg1_d  = req_neg1;
          neg2_d  = req_neg2;
          divz_d  = req_divz;
          count_d = '0;
          rem_d   = '0;
          dvsr_d  = req_mag2;
          if (req_divz || req_ovf) begin
            // Raw dividend is kept: it is the divide-by-zero remainder
            quo_d   = rs1_data;
            state_d = SPECIAL;
          end else begin
            quo_d   = req_mag1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d   = rem_nx;
        quo_d   = quo_nx;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          result_d = op_q[1] ? r_fix : q_fix;
          state_d  = DONE;
        end
      end
      SPECIAL: begin
        if (divz_q) result_d = op_q[1] ? quo_q : '1;
        else        result_d = op_q[1] ? '0    : INT_MIN;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      op_q     <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      divz_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      op_q     <= op_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      divz_q   <= divz_d;
      result_q <= result_d;
    end
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    busy   = (state_q == CALC) || (state_q == SPECIAL);
    done   = (state_q == DONE);
    result = result_q;
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: vector table plus hand-written sequences
// for restart-while-busy, flush and asynchronous reset mid-operation.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  fn3;
  logic        flush;
  logic [31:0] rs1_data, rs2_data;
  logic        busy, done;
  logic [31:0] result;

  int cyc    = 0;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  div_sequencer #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .fn3      (fn3),
    .flush    (flush),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present a request; returns just after the edge that samples it (cycle 1)
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    fn3      = f;
    rs1_data = a;
    rs2_data = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
  endtask

  // Wait (bounded) for done; busy must be high in every cycle before it
  task automatic wait_done(output int dcyc, output logic busy_ok);
    busy_ok = 1'b1;
    while (!done && cyc < 45) begin
      if (!busy) busy_ok = 1'b0;
      step();
    end
    if (busy) busy_ok = 1'b0;
    dcyc = done ? cyc : -1;
  endtask

  int   dcyc;
  logic bok;
  logic saw_done;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; fn3 = 3'b000; flush = 1'b0;
    rs1_data = '0; rs2_data = '0;

    vecs.push_back('{3'b100, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{3'b110, 32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd3,          32'hFFFF_FFFF,  33});
    vecs.push_back('{3'b110, 32'd7,          32'hFFFF_FFFD,  32'd1,          33});
    vecs.push_back('{3'b101, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33});
    vecs.push_back('{3'b111, 32'hFFFF_FFFF,  32'h10,         32'hF,          33});
    vecs.push_back('{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  2});
    vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2});
    vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2});
    vecs.push_back('{3'b111, 32'd5,          32'd0,          32'd5,          2});
    vecs.push_back('{3'b100, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  2});
    vecs.push_back('{3'b110, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8,  2});
    vecs.push_back('{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
    vecs.push_back('{3'b100, 32'h8000_0000,  32'd2,          32'hC000_0000,  33});
    vecs.push_back('{3'b100, 32'd100,        32'd7,          32'd14,         33});

    // Reset state
    #12;
    check("reset_busy",   {31'd0, busy},  32'd0);
    check("reset_done",   {31'd0, done},  32'd0);
    check("reset_result", result,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // start with fn3[2]=0 belongs to the ALU and must be ignored
    issue(3'b001, 32'd100, 32'd7);
    check("alu_op_busy", {31'd0, busy}, 32'd0);
    step();
    check("alu_op_done", {31'd0, done}, 32'd0);

    // Table of operations
    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_done(dcyc, bok);
      check($sformatf("vec%0d_done_cycle", i), 32'(dcyc), 32'(vecs[i].cyc));
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_busy", i), {31'd0, bok}, 32'd1);
      step();
      check($sformatf("vec%0d_idle", i), {30'd0, busy, done}, 32'd0);
    end

    // A second start while busy is ignored
    issue(3'b100, 32'd100, 32'd7);
    while (cyc < 10) step();
    start = 1'b1; fn3 = 3'b101; rs1_data = 32'd50; rs2_data = 32'd5;
    step();
    start = 1'b0;
    wait_done(dcyc, bok);
    check("restart_done_cycle", 32'(dcyc), 32'd33);
    check("restart_result", result, 32'd14);
    check("restart_busy", {31'd0, bok}, 32'd1);
    step();

    // Flush in cycle 10: idle in cycle 11, no done, result kept
    issue(3'b100, 32'd50, 32'd7);
    while (cyc < 10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result", result, 32'd14);
    saw_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done || busy) saw_done = 1'b1;
      step();
    end
    check("flush_quiet", {31'd0, saw_done}, 32'd0);

    // Asynchronous reset mid-operation, then recovery
    issue(3'b101, 32'd1000, 32'd3);
    while (cyc < 15) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_busy",   {31'd0, busy}, 32'd0);
    check("areset_done",   {31'd0, done}, 32'd0);
    check("areset_result", result,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b101, 32'd9, 32'd3);
    wait_done(dcyc, bok);
    check("post_reset_done_cycle", 32'(dcyc), 32'd33);
    check("post_reset_result", result, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
